// File: rtl/ads8588h_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ads8588h_seq_ctrl_if
// Purpose  : ADC pin bundle plus sample stream of the ADS8588H sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ads8588h_seq_ctrl_if;
   logic        enable;
   logic        single;
   logic        convst_n;
   logic        adc_busy;
   logic        adc_cs_n;
   logic        adc_rd_n;
   logic [15:0] adc_db;
   logic [15:0] sample_data;
   logic [2:0]  sample_ch;
   logic        sample_valid;
   logic        frame_done;
   logic        overrun;
   logic        timeout_err;
   logic        active;

   // master: the sequencer, which drives the ADC strobes and the sample stream
   modport master (
      input  enable, single, adc_busy, adc_db,
      output convst_n, adc_cs_n, adc_rd_n, sample_data, sample_ch,
             sample_valid, frame_done, overrun, timeout_err, active
   );

   // slave: host controls, ADC model and sample consumer
   modport slave (
      output enable, single, adc_busy, adc_db,
      input  convst_n, adc_cs_n, adc_rd_n, sample_data, sample_ch,
             sample_valid, frame_done, overrun, timeout_err, active
   );
endinterface
`default_nettype wire

// File: rtl/ads8588h_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ads8588h_seq_ctrl
// Purpose  : Starts ADS8588H conversions, waits out BUSY and reads NUM_CH words.
// Revision : 1.0 - initial release
// ============================================================================
module ads8588h_seq_ctrl #(
   parameter int NUM_CH     = 8,
   parameter int PERIOD     = 100,
   parameter int CONVST_LOW = 2,
   parameter int RD_LOW     = 2,
   parameter int RD_HIGH    = 2,
   parameter int BUSY_TO    = 40
) (
   input  wire logic          rd_sclk,
   input  wire logic          reset,
   ads8588h_seq_ctrl_if.master bus
);

   localparam int c_tmax_a = (CONVST_LOW > BUSY_TO) ? CONVST_LOW : BUSY_TO;
   localparam int c_tmax_b = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
   localparam int c_tmax   = (c_tmax_a > c_tmax_b) ? c_tmax_a : c_tmax_b;
   localparam int c_tw     = $clog2(c_tmax + 1);
   localparam int c_pw     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [c_tw-1:0] c_conv_end = c_tw'(CONVST_LOW - 1);
   localparam logic [c_tw-1:0] c_busy_end = c_tw'(BUSY_TO - 1);
   localparam logic [c_tw-1:0] c_rdl_end  = c_tw'(RD_LOW - 1);
   localparam logic [c_tw-1:0] c_rdh_end  = c_tw'(RD_HIGH - 1);
   localparam logic [c_pw-1:0] c_per_end  = c_pw'(PERIOD - 1);
   localparam logic [2:0]      c_last_ch  = 3'(NUM_CH - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVST  = 3'd1,
      ST_WAIT_BH = 3'd2,
      ST_WAIT_BL = 3'd3,
      ST_RD_L    = 3'd4,
      ST_RD_H    = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [c_tw-1:0]   tmr_q, tmr_d;
   logic [2:0]        ch_q, ch_d;
   logic [c_pw-1:0]   per_q, per_d;
   logic              busy_meta_q, busy_s_q;
   logic              convst_n_q, cs_n_q, rd_n_q, active_q;
   logic [15:0]       data_q, data_d;
   logic [2:0]        sch_q, sch_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
   logic              to_q, to_d;
   logic              per_wrap;
   logic              trig;

   always_comb begin
      per_d = '0;
      if (bus.enable && (per_q != c_per_end))
         per_d = per_q + 1'b1;
   end

   assign per_wrap = bus.enable && (per_q == c_per_end);
   assign trig     = per_wrap || bus.single;

   // tmr counts cycles spent in the current state; every transition restarts it
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      ch_d    = ch_q;
      data_d  = data_q;
      sch_d   = sch_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      to_d    = to_q;
      ovr_d   = trig && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            tmr_d = '0;
            if (trig) begin
               state_d = ST_CONVST;
               to_d    = 1'b0;
            end
         end
         ST_CONVST: begin
            if (tmr_q == c_conv_end) begin
               state_d = ST_WAIT_BH;
               tmr_d   = '0;
            end
         end
         ST_WAIT_BH: begin
            if (busy_s_q) begin
               state_d = ST_WAIT_BL;
               tmr_d   = '0;
            end else if (tmr_q == c_busy_end) begin
               state_d = ST_IDLE;
               to_d    = 1'b1;
            end
         end
         ST_WAIT_BL: begin
            if (!busy_s_q) begin
               state_d = ST_RD_L;
               tmr_d   = '0;
               ch_d    = '0;
            end else if (tmr_q == c_busy_end) begin
               state_d = ST_IDLE;
               to_d    = 1'b1;
            end
         end
         ST_RD_L: begin
            if (tmr_q == c_rdl_end) begin
               state_d = ST_RD_H;
               tmr_d   = '0;
               data_d  = bus.adc_db;
               sch_d   = ch_q;
               valid_d = 1'b1;
            end
         end
         ST_RD_H: begin
            if (tmr_q == c_rdh_end) begin
               tmr_d = '0;
               if (ch_q == c_last_ch) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RD_L;
                  ch_d    = ch_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            tmr_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Strobes are decoded from the next state so that they leave the flops in step with it
   always_ff @(posedge rd_sclk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         ch_q        <= '0;
         per_q       <= '0;
         busy_meta_q <= 1'b0;
         busy_s_q    <= 1'b0;
         convst_n_q  <= 1'b1;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         active_q    <= 1'b0;
         data_q      <= '0;
         sch_q       <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         ch_q        <= ch_d;
         per_q       <= per_d;
         busy_meta_q <= bus.adc_busy;
         busy_s_q    <= busy_meta_q;
         convst_n_q  <= (state_d != ST_CONVST);
         cs_n_q      <= !((state_d == ST_RD_L) || (state_d == ST_RD_H));
         rd_n_q      <= (state_d != ST_RD_L);
         active_q    <= (state_d != ST_IDLE);
         data_q      <= data_d;
         sch_q       <= sch_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
         to_q        <= to_d;
      end
   end

   assign bus.convst_n     = convst_n_q;
   assign bus.adc_cs_n     = cs_n_q;
   assign bus.adc_rd_n     = rd_n_q;
   assign bus.sample_data  = data_q;
   assign bus.sample_ch    = sch_q;
   assign bus.sample_valid = valid_q;
   assign bus.frame_done   = done_q;
   assign bus.overrun      = ovr_q;
   assign bus.timeout_err  = to_q;
   assign bus.active       = active_q;

endmodule
`default_nettype wire

// File: tb/tb_ads8588h_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads8588h_seq_ctrl
// Purpose  : Scoreboard bench with a behavioural ADS8588H model for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ads8588h_seq_ctrl;
   localparam int NUM_CH     = 8;
   localparam int PERIOD     = 100;
   localparam int CONVST_LOW = 2;
   localparam int RD_LOW     = 2;
   localparam int RD_HIGH    = 2;
   localparam int BUSY_TO    = 40;
   localparam int M_RAND = 0, M_FIX = 1, M_NEVER = 2, M_STUCK = 3;

   logic rd_sclk = 1'b0;
   logic reset   = 1'b1;
   ads8588h_seq_ctrl_if bus ();

   ads8588h_seq_ctrl #(
      .NUM_CH(NUM_CH), .PERIOD(PERIOD), .CONVST_LOW(CONVST_LOW),
      .RD_LOW(RD_LOW), .RD_HIGH(RD_HIGH), .BUSY_TO(BUSY_TO)
   ) dut (
      .rd_sclk (rd_sclk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 rd_sclk = ~rd_sclk;

   int cyc = 0;
   always @(posedge rd_sclk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Scoreboard state
   logic [18:0] exp_q[$];
   int exp_start[$];
   int exp_ovr[$];
   int exp_frames = 0, got_frames = 0, samples_in_frame = 0;

   // ADC model: BUSY profile after each CONVST rise, one result word per RD pulse
   int mode = M_FIX, fix_d = 3, fix_w = 10;
   bit data_fixed = 1'b0;
   logic [15:0] conv_data[NUM_CH];
   int age = 1000, cur_d = 0, cur_w = 0, rdidx = 0;
   logic a_prev_convst = 1'b1, a_prev_rd = 1'b1;

   always @(negedge rd_sclk) begin
      if (!a_prev_convst && bus.convst_n === 1'b1) begin
         age = 0;
         case (mode)
            M_RAND:  begin cur_d = $urandom_range(1, 8); cur_w = $urandom_range(3, 30); end
            M_FIX:   begin cur_d = fix_d; cur_w = fix_w; end
            M_NEVER: begin cur_d = 0; cur_w = 0; end
            default: begin cur_d = 3; cur_w = 80; end
         endcase
         for (int k = 0; k < NUM_CH; k++) begin
            conv_data[k] = data_fixed ? 16'(16'h1000 + k) : 16'($urandom);
            if (mode == M_RAND || mode == M_FIX) exp_q.push_back({3'(k), conv_data[k]});
         end
         if (mode == M_RAND || mode == M_FIX) exp_frames++;
      end else if (age < 100000) begin
         age++;
      end
      bus.adc_busy = (age >= cur_d) && (age < cur_d + cur_w);
      if (bus.adc_cs_n !== 1'b0) rdidx = 0;
      else if (!a_prev_rd && bus.adc_rd_n === 1'b1) rdidx++;
      if (bus.adc_cs_n === 1'b0 && bus.adc_rd_n === 1'b0 && rdidx < NUM_CH)
         bus.adc_db = conv_data[rdidx[2:0]];
      else
         bus.adc_db = 16'($urandom);
      a_prev_convst = bus.convst_n;
      a_prev_rd     = bus.adc_rd_n;
   end

   // Monitor
   logic m_prev_convst = 1'b1, m_prev_cs = 1'b1, m_prev_rd = 1'b1, m_prev_to = 1'b0;
   int convst_len = 0, cs_len = 0, rd_len = 0, rise_cyc = 0, to_delay = 0;
   bit cs_seen = 1'b0, to_seen = 1'b0;
   logic [18:0] e;

   always @(negedge rd_sclk) begin
      if (!reset) begin
         m_prev_convst = 1'b1; m_prev_cs = 1'b1; m_prev_rd = 1'b1; m_prev_to = 1'b0;
         convst_len = 0; cs_len = 0; rd_len = 0;
      end else begin
         if (m_prev_convst && !bus.convst_n) begin
            cs_seen = 1'b0;
            convst_len = 0;
            if (exp_start.size() == 0) fail_now("unexpected frame start");
            else check("frame start cycle", cyc, exp_start.pop_front());
         end
         if (!bus.convst_n) convst_len++;
         if (!m_prev_convst && bus.convst_n) begin
            check("convst_n low width", convst_len, CONVST_LOW);
            rise_cyc = cyc;
         end
         if (!bus.adc_cs_n) begin cs_len++; cs_seen = 1'b1; end
         if (!m_prev_cs && bus.adc_cs_n) begin
            check("cs_n low width", cs_len, NUM_CH * (RD_LOW + RD_HIGH));
            cs_len = 0;
         end
         if (m_prev_rd && !bus.adc_rd_n) check("cs_n low at rd_n fall", bus.adc_cs_n, 1'b0);
         if (!bus.adc_rd_n) rd_len++;
         if (!m_prev_rd && bus.adc_rd_n) begin
            check("rd_n low width", rd_len, RD_LOW);
            rd_len = 0;
         end
         if (bus.sample_valid) begin
            if (exp_q.size() == 0) fail_now("unexpected sample_valid");
            else begin
               e = exp_q.pop_front();
               check("sample_ch", bus.sample_ch, e[18:16]);
               check("sample_data", bus.sample_data, e[15:0]);
            end
            samples_in_frame++;
         end
         if (bus.frame_done) begin
            check("samples per frame", samples_in_frame, NUM_CH);
            check("timeout_err at frame_done", bus.timeout_err, 1'b0);
            samples_in_frame = 0;
            got_frames++;
         end
         if (bus.overrun) begin
            if (exp_ovr.size() == 0) fail_now("unexpected overrun");
            else check("overrun cycle", cyc, exp_ovr.pop_front());
         end
         if (!m_prev_to && bus.timeout_err) begin
            to_seen  = 1'b1;
            to_delay = cyc - rise_cyc;
         end
         m_prev_convst = bus.convst_n;
         m_prev_cs     = bus.adc_cs_n;
         m_prev_rd     = bus.adc_rd_n;
         m_prev_to     = bus.timeout_err;
      end
   end

   // Stimulus helpers (called at a negedge)
   task automatic drive_single(input bit accepted, input bit ovr);
      bus.single = 1'b1;
      if (accepted) exp_start.push_back(cyc + 1);
      if (ovr) exp_ovr.push_back(cyc + 1);
      @(negedge rd_sclk);
      bus.single = 1'b0;
   endtask

   task automatic pulse_single();
      @(negedge rd_sclk);
      drive_single(1'b1, 1'b0);
   endtask

   task automatic goto_edge(input int edge_no);
      @(negedge rd_sclk);
      while (cyc < edge_no - 1) @(negedge rd_sclk);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (bus.active && n < budget) begin
         @(negedge rd_sclk);
         n++;
      end
      if (bus.active) fail_now("frame did not return to idle");
      repeat (4) @(negedge rd_sclk);
   endtask

   localparam logic [27:0] c_rst_vec = {3'b111, 16'h0, 3'h0, 5'b00000};

   initial begin
      int e0, n;
      bus.enable = 1'b0;
      bus.single = 1'b0;
      #1 reset = 1'b0;
      repeat (3) @(negedge rd_sclk);
      check("reset outputs", {bus.convst_n, bus.adc_cs_n, bus.adc_rd_n, bus.sample_data,
            bus.sample_ch, bus.sample_valid, bus.frame_done, bus.overrun,
            bus.timeout_err, bus.active}, c_rst_vec);
      reset = 1'b1;
      repeat (3) @(negedge rd_sclk);
      check("idle after release", {bus.convst_n, bus.adc_cs_n, bus.adc_rd_n, bus.sample_data,
            bus.sample_ch, bus.sample_valid, bus.frame_done, bus.overrun,
            bus.timeout_err, bus.active}, c_rst_vec);

      // Single frame with data 0x1000+ch
      data_fixed = 1'b1; mode = M_FIX; fix_d = 3; fix_w = 10;
      pulse_single();
      wait_idle(200);
      data_fixed = 1'b0;

      // Random single frames
      mode = M_RAND;
      repeat (6) begin
         pulse_single();
         wait_idle(200);
         repeat ($urandom_range(1, 20)) @(negedge rd_sclk);
      end

      // Periodic; a single coinciding with the second wrap merges into it
      @(negedge rd_sclk);
      bus.enable = 1'b1;
      e0 = cyc + 1;
      for (int k = 1; k <= 3; k++) exp_start.push_back(e0 + k * PERIOD - 1);
      goto_edge(e0 + 2 * PERIOD - 1);
      drive_single(1'b0, 1'b0);
      goto_edge(e0 + 350);
      bus.enable = 1'b0;
      wait_idle(200);
      repeat (120) @(negedge rd_sclk);

      // Overrun: triggers during long-BUSY frames are dropped and flagged
      mode = M_FIX; fix_d = 3; fix_w = 30;
      @(negedge rd_sclk);
      bus.enable = 1'b1;
      e0 = cyc + 1;
      exp_start.push_back(e0 + PERIOD - 1);
      goto_edge(e0 + 119); drive_single(1'b0, 1'b1);
      goto_edge(e0 + 149); drive_single(1'b0, 1'b1);
      goto_edge(e0 + 185); drive_single(1'b1, 1'b0);
      exp_ovr.push_back(e0 + 2 * PERIOD - 1);
      exp_start.push_back(e0 + 3 * PERIOD - 1);
      goto_edge(e0 + 310);
      bus.enable = 1'b0;
      wait_idle(200);

      // BUSY never rises
      mode = M_NEVER; to_seen = 1'b0;
      pulse_single();
      wait_idle(100);
      check("timeout_err after missing BUSY", bus.timeout_err, 1'b1);
      check("timeout seen (WAIT_BH)", to_seen, 1'b1);
      check("WAIT_BH timeout delay", to_delay, BUSY_TO);
      check("cs_n untouched (WAIT_BH)", cs_seen, 1'b0);
      mode = M_FIX; fix_d = 3; fix_w = 10;
      pulse_single();
      check("timeout_err cleared by trigger", bus.timeout_err, 1'b0);
      wait_idle(200);

      // BUSY stuck high
      mode = M_STUCK; to_seen = 1'b0;
      pulse_single();
      wait_idle(150);
      check("timeout_err after stuck BUSY", bus.timeout_err, 1'b1);
      check("timeout seen (WAIT_BL)", to_seen, 1'b1);
      check("WAIT_BL timeout delay in range",
            (to_delay >= BUSY_TO + 3) && (to_delay <= BUSY_TO + 9), 1'b1);
      check("cs_n untouched (WAIT_BL)", cs_seen, 1'b0);
      repeat (100) @(negedge rd_sclk);

      // Async reset during RD_L of channel 3
      mode = M_FIX; fix_d = 3; fix_w = 10;
      pulse_single();
      n = 0;
      while (!(samples_in_frame == 3 && bus.adc_rd_n == 1'b0) && n < 200) begin
         @(negedge rd_sclk);
         n++;
      end
      if (n >= 200) fail_now("channel 3 read not reached");
      #2 reset = 1'b0;
      exp_q.delete();
      exp_frames--;
      samples_in_frame = 0;
      #1;
      check("strobes/active at async reset",
            {bus.convst_n, bus.adc_cs_n, bus.adc_rd_n, bus.active}, 4'b1110);
      repeat (3) @(negedge rd_sclk);
      reset = 1'b1;
      repeat (3) @(negedge rd_sclk);
      pulse_single();
      wait_idle(200);

      check("leftover expected samples", exp_q.size(), 0);
      check("leftover expected starts", exp_start.size(), 0);
      check("leftover expected overruns", exp_ovr.size(), 0);
      check("frames completed", got_frames, exp_frames);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
